// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg
// Shared types and helpers for the boot-time flash loader.
//   loader_state_t : loader FSM encoding (idle, loading, draining the last
//                    write, waiting out the release delay, core running).
//   word_aligned() : true when a byte address sits on a word boundary for a
//                    given data width.
package flash_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DRAIN,
    LD_WAIT,
    LD_RUN
  } loader_state_t;

  // width is in bits and must be a power-of-two multiple of 8.
  function automatic logic word_aligned(input logic [31:0] addr, input int unsigned width);
    logic [31:0] mask;
    mask = (width / 8) - 1;
    return (addr & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/flash_loader_release_cnt.sv
// flash_loader_release_cnt
// Down-counter that times the gap between the last memory write retiring
// and the core being let out of reset.
//   clk       in   clock
//   rst_ni    in   asynchronous active-low reset
//   load_i    in   load load_val_i (has priority over decrement)
//   load_val_i in  value to load
//   dec_i     in   decrement by one, holding at zero
//   zero_o    out  counter is zero
module flash_loader_release_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/flash_loader.sv
// flash_loader
// Boot-time program loader: takes word beats from the host flash stream over
// a valid/ready handshake, writes them to the unified memory through a single
// registered write port, and releases the core from reset a fixed number of
// cycles after the final write has retired.
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   s_valid    in   beat valid
//   s_ready    out  loader can accept a beat this cycle
//   s_addr     in   byte address (ignored when s_burst=1)
//   s_data     in   word to write
//   s_burst    in   1 = address is previous accepted address + WIDTH/8
//   s_last     in   final beat of the image
//   mem_ready  in   memory accepts the presented write this cycle
//   mem_we     out  memory write strobe
//   mem_addr   out  memory byte address
//   mem_wdata  out  memory write data
//   core_run   out  core may leave reset
//   done       out  image loaded without error (sticky)
//   err        out  sticky: misaligned or out-of-range beat seen
//   word_count out  words written since reset (saturating)
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 11,
  parameter int DEPTH_WORDS = 512,
  parameter int RELEASE_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_burst,
  input  logic              s_last,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              core_run,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  localparam int                STEP_BYTES = WIDTH / 8;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(STEP_BYTES);
  localparam logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'((DEPTH_WORDS - 1) * STEP_BYTES);
  localparam int                CNT_W      = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
  localparam logic [CNT_W-1:0]  REL_LOAD   = CNT_W'(RELEASE_CYC - 1);

  loader_state_t     state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              first_q, first_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;

  logic              wr_free;
  logic              accept;
  logic              retire;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_ok;
  logic              rel_load;
  logic              rel_dec;
  logic              rel_zero;

  // The output register is the only buffer: a new beat fits only when the
  // register is empty or its write retires on this same edge. Gating with
  // rst keeps ready low for the whole reset interval.
  assign wr_free = ~mem_we_q | mem_ready;
  assign s_ready = rst & ((state_q == LD_IDLE) | (state_q == LD_LOAD)) & wr_free;
  assign accept  = s_valid & s_ready;
  assign retire  = mem_we_q & mem_ready;

  // Burst addresses wrap at 2^ADDR_W naturally; the first burst beat after
  // reset has no predecessor and starts at zero.
  assign beat_addr = s_burst ? (first_q ? '0 : last_addr_q + STEP) : s_addr;
  assign beat_ok   = word_aligned(32'(beat_addr), WIDTH) && (beat_addr <= MAX_ADDR);

  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    last_addr_d = last_addr_q;
    first_d     = first_q;
    err_d       = err_q;
    wcnt_d      = wcnt_q;

    if (retire) begin
      mem_we_d = 1'b0;
    end
    // A dropped beat still becomes the burst reference address.
    if (accept) begin
      last_addr_d = beat_addr;
      first_d     = 1'b0;
      if (beat_ok) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = beat_addr;
        mem_wdata_d = s_data;
      end else begin
        err_d = 1'b1;
      end
    end
    if (retire && (wcnt_q != '1)) begin
      wcnt_d = wcnt_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    rel_load = 1'b0;
    rel_dec  = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (accept) begin
          state_d = s_last ? LD_DRAIN : LD_LOAD;
        end
      end
      LD_LOAD: begin
        if (accept && s_last) begin
          state_d = LD_DRAIN;
        end
      end
      LD_DRAIN: begin
        // Leave once the final write retires, or at once if it was dropped.
        if (wr_free) begin
          state_d  = LD_WAIT;
          rel_load = 1'b1;
        end
      end
      LD_WAIT: begin
        rel_dec = 1'b1;
        if (rel_zero) begin
          state_d = LD_RUN;
        end
      end
      LD_RUN: begin
        state_d = LD_RUN;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LD_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      last_addr_q <= '0;
      first_q     <= 1'b1;
      err_q       <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      last_addr_q <= last_addr_d;
      first_q     <= first_d;
      err_q       <= err_d;
      wcnt_q      <= wcnt_d;
    end
  end

  flash_loader_release_cnt #(
    .W (CNT_W)
  ) u_release_cnt (
    .clk        (clk),
    .rst_ni     (rst),
    .load_i     (rel_load),
    .load_val_i (REL_LOAD),
    .dec_i      (rel_dec),
    .zero_o     (rel_zero)
  );

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_run   = (state_q == LD_RUN);
  assign done       = core_run & ~err_q;
  assign err        = err_q;
  assign word_count = wcnt_q;

endmodule
